// File: rtl/bs_pkg.sv
// Shared constants and state encoding for the bit-stuffing encoder.
package bs_pkg;

  localparam int STUFF_RUN = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } bs_state_e;

endpackage

// File: rtl/bit_stuff_encode_fsm.sv
// Control FSM for the bit-stuffing encoder: state, handshake and counter strobes.
// BIT_STUFF_TRAILING_EN: also stuff after a packet's final bit when it completes a run.
module bit_stuff_encode_fsm
  import bs_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in_valid_i,
  input  logic in_bit_i,
  input  logic in_last_i,
  input  logic run_hit_i,
  output logic in_ready_o,
  output logic xfer_o,
  output logic stuff_o,
  output logic cnt_inc_o,
  output logic cnt_clr_o,
  output logic data_last_o,
  output logic stuff_last_o
);

  bs_state_e state_q, state_d;
  logic      go_stuff;

  assign stuff_o    = (state_q == STUFF);
  assign in_ready_o = !stuff_o;
  assign xfer_o     = in_valid_i && in_ready_o;

`ifdef BIT_STUFF_TRAILING_EN
  logic lpend_q, lpend_d;

  assign go_stuff     = xfer_o && run_hit_i;
  assign stuff_last_o = lpend_q;

  always_comb begin
    lpend_d = lpend_q;
    if (go_stuff)
      lpend_d = in_last_i;
    else if (stuff_o)
      lpend_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lpend_q <= 1'b0;
    else       lpend_q <= lpend_d;
  end
`else
  assign go_stuff     = xfer_o && run_hit_i && !in_last_i;
  assign stuff_last_o = 1'b0;
`endif

  // a data bit carries out_last only when no stuff follows it
  assign data_last_o = in_last_i && !go_stuff;
  assign cnt_inc_o   = xfer_o && in_bit_i && !in_last_i;
  assign cnt_clr_o   = stuff_o
                    || (xfer_o && (!in_bit_i || in_last_i));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, SEND: begin
        if (xfer_o) begin
          if (go_stuff)       state_d = STUFF;
          else if (in_last_i) state_d = IDLE;
          else                state_d = SEND;
        end
      end
      STUFF:   state_d = stuff_last_o ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/bit_stuff_encode.sv
// Bit-stuffing encoder: inserts a 0 after RUN_LEN consecutive ones.
// BIT_STUFF_TRAILING_EN: also stuff after a packet's final bit when it completes a run.
module bit_stuff_encode
  import bs_pkg::*;
#(
  parameter int RUN_LEN = bs_pkg::STUFF_RUN
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  output logic out_stuffed
);

  localparam int CW = $clog2(RUN_LEN + 1);

  logic [CW-1:0] ones_cnt_q, ones_cnt_d;
  logic          valid_q, valid_d;
  logic          bit_q, bit_d;
  logic          last_q, last_d;
  logic          stf_q, stf_d;
  logic          run_hit, xfer, stuff;
  logic          cnt_inc, cnt_clr;
  logic          data_last, stuff_last;

  // the bit being offered would complete a run of RUN_LEN ones
  assign run_hit = in_bit
                && (ones_cnt_q == CW'(RUN_LEN - 1));

  bit_stuff_encode_fsm u_fsm (
    .clock        (clock),
    .reset        (reset),
    .in_valid_i   (in_valid),
    .in_bit_i     (in_bit),
    .in_last_i    (in_last),
    .run_hit_i    (run_hit),
    .in_ready_o   (in_ready),
    .xfer_o       (xfer),
    .stuff_o      (stuff),
    .cnt_inc_o    (cnt_inc),
    .cnt_clr_o    (cnt_clr),
    .data_last_o  (data_last),
    .stuff_last_o (stuff_last)
  );

  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (cnt_clr)
      ones_cnt_d = '0;
    else if (cnt_inc)
      ones_cnt_d = ones_cnt_q + 1'b1;
  end

  always_comb begin
    valid_d = 1'b0;
    bit_d   = bit_q;
    last_d  = 1'b0;
    stf_d   = 1'b0;
    if (stuff) begin
      valid_d = 1'b1;
      bit_d   = 1'b0;
      last_d  = stuff_last;
      stf_d   = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b1;
      bit_d   = in_bit;
      last_d  = data_last;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ones_cnt_q <= '0;
      valid_q    <= 1'b0;
      bit_q      <= 1'b0;
      last_q     <= 1'b0;
      stf_q      <= 1'b0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
      valid_q    <= valid_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      stf_q      <= stf_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_bit     = bit_q;
  assign out_last    = last_q;
  assign out_stuffed = stf_q;

endmodule

// File: tb/tb_bit_stuff_encode.sv
// Scoreboard bench for bit_stuff_encode (honours BIT_STUFF_TRAILING_EN).
module tb_bit_stuff_encode;
  import bs_pkg::*;

  localparam int RL = STUFF_RUN;
`ifdef BIT_STUFF_TRAILING_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif
  localparam int PAUSE = 4;

  logic clock = 1'b0;
  logic reset, in_valid, in_bit, in_last;
  logic in_ready, out_valid, out_bit;
  logic out_last, out_stuffed;

  bit_stuff_encode #(.RUN_LEN(RL)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .out_last    (out_last),
    .out_stuffed (out_stuffed)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic v;
    logic b;
    logic l;
    logic s;
    logic cb;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_run  = 0;
  bit   m_pend = 1'b0;
  bit   m_plast = 1'b0;

  task automatic chk(input string tag,
                     input logic act,
                     input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b want %b",
               tag, $time, act, exp);
    end
  endtask

  task automatic push(input logic v, input logic b,
                      input logic l, input logic s,
                      input logic cb);
    exp_t e;
    e.v = v; e.b = b; e.l = l; e.s = s; e.cb = cb;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("out_valid", out_valid, e.v);
    if (e.v || e.cb) chk("out_bit", out_bit, e.b);
    chk("out_last", out_last, e.l);
    chk("out_stuffed", out_stuffed, e.s);
  endtask

  // token: bit0 = data, bit1 = last, PAUSE = idle cycle
  task automatic step(input int t, output bit used);
    logic tb0, tb1;
    tb0 = t[0];
    tb1 = t[1];
    @(negedge clock);
    check_out();
    used = 1'b1;
    if (m_pend) begin
      chk("in_ready_stuff", in_ready, 1'b0);
      push(1'b1, 1'b0, m_plast, 1'b1, 1'b0);
      m_pend = 1'b0;
      m_run  = 0;
      used   = 1'b0;
      in_valid = (t != PAUSE);
      in_bit   = tb0;
      in_last  = tb1;
    end else begin
      chk("in_ready", in_ready, 1'b1);
      if (t == PAUSE) begin
        in_valid = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        in_valid = 1'b1;
        in_bit   = tb0;
        in_last  = tb1;
        m_run = tb0 ? m_run + 1 : 0;
        if (m_run == RL && (!tb1 || TRAIL)) begin
          m_pend  = 1'b1;
          m_plast = tb1;
          push(1'b1, tb0, 1'b0, 1'b0, 1'b0);
        end else begin
          push(1'b1, tb0, tb1, 1'b0, 1'b0);
          if (tb1) m_run = 0;
        end
      end
    end
  endtask

  task automatic feed(input int t);
    bit u;
    int k;
    u = 1'b0;
    k = 0;
    while (!u && k < 4) begin
      step(t, u);
      k++;
    end
    if (!u) chk("feed_stall", 1'b0, 1'b1);
  endtask

  task automatic feed_n(input int t, input int n);
    for (int i = 0; i < n; i++) feed(t);
  endtask

  task automatic do_reset();
    @(negedge clock);
    check_out();
    chk("in_ready_pre_rst", in_ready, !m_pend);
    reset    = 1'b1;
    in_valid = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_pend = 1'b0;
    m_run  = 0;
    @(negedge clock);
    check_out();
    chk("in_ready_rst", in_ready, 1'b1);
    reset = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    in_last  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bit", out_bit, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_stuffed", out_stuffed, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    reset    = 1'b0;

    // eight ones, last on the eighth
    feed_n(1, 7);
    feed(3);
    feed_n(PAUSE, 2);

    // alternating pattern, never stuffs
    for (int i = 0; i < 7; i++) feed(i % 2 == 0 ? 1 : 0);
    feed(2);
    feed_n(PAUSE, 2);

    // exactly RL ones, last on the final one
    feed_n(1, RL - 1);
    feed(3);
    feed_n(PAUSE, 2);

    // paused run keeps its count
    feed_n(1, 3);
    feed_n(PAUSE, 2);
    feed_n(1, 3);
    feed(3);
    feed_n(PAUSE, 2);

    // a zero breaks the first run
    feed_n(1, 5);
    feed(0);
    feed_n(1, 6);
    feed(2);
    feed_n(PAUSE, 2);

    // reset while stuffing, then a fresh packet
    feed_n(1, RL);
    do_reset();
    feed_n(1, RL);
    feed(2);
    feed_n(PAUSE, 3);

    @(negedge clock);
    check_out();
    chk("sb_empty", sb.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
